// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word_serializer wide-to-narrow stream block.
// Optional out_parity generation is enabled by defining WORD_SERIALIZER_PARITY_EN.
package word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WORD_W = 32;
    localparam int DEFAULT_LANE_W = 8;

    function automatic int lane_count(input int word_w, input int lane_w);
        return word_w / lane_w;
    endfunction

endpackage

// File: rtl/word_serializer_lane_reduce.sv
// Combinational AND/OR/XOR reduction of one lane.
// Only built when WORD_SERIALIZER_PARITY_EN is defined.
module lane_reduce #(
    parameter int W = 8
) (
    input  logic [W-1:0] din,
    output logic         and_o,
    output logic         or_o,
    output logic         xor_o
);

    assign and_o = &din;
    assign or_o  = |din;
    assign xor_o = ^din;

endmodule

// File: rtl/word_serializer.sv
// Wide-to-narrow serializer: one WORD_W word in, WORD_W/LANE_W lanes out, LSB- or MSB-lane first.
// Define WORD_SERIALIZER_PARITY_EN to register out_parity = ^out_data; otherwise it is tied to 0.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W,
    parameter int LANE_W = DEFAULT_LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_msb_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_last,
    output logic              out_parity,
    output logic              busy
);

    localparam int N     = lane_count(WORD_W, LANE_W);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    if (((WORD_W % LANE_W) != 0) || (N < 2)) begin : g_bad_cfg
        $fatal(1, "word_serializer: WORD_W must be a multiple of LANE_W with at least 2 lanes");
    end

    // Handshake rule: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and in_ready may rise on the last-lane beat.
    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                msb_q, msb_d;
    logic                out_valid_q, out_valid_d;
    logic [LANE_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                out_parity_q, out_parity_d;
    logic                in_hs;
    logic                out_hs;

    function automatic logic [LANE_W-1:0] pick_lane(input logic [WORD_W-1:0] w,
                                                    input logic [CNT_W-1:0]  idx);
        logic [LANE_W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == CNT_W'(k)) r = w[k*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    assign in_ready = rst_n && (!out_valid_q || (out_ready && out_last_q));
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        msb_d       = msb_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        // A new word wins over the final-lane beat, giving gap-free back-to-back words.
        if (in_hs) begin
            state_d     = SHIFT;
            word_d      = in_data;
            cnt_d       = '0;
            msb_d       = in_msb_first;
            out_valid_d = 1'b1;
            out_data_d  = pick_lane(in_data, in_msb_first ? LAST_IDX : '0);
            out_last_d  = 1'b0;
        end else if (out_hs) begin
            if (out_last_q) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                cnt_d      = cnt_q + 1'b1;
                out_data_d = pick_lane(word_q, msb_q ? (LAST_IDX - cnt_d) : cnt_d);
                out_last_d = (cnt_d == LAST_IDX);
            end
        end
    end

`ifdef WORD_SERIALIZER_PARITY_EN
    logic unused_red_and;
    logic unused_red_or;

    lane_reduce #(.W(LANE_W)) u_lane_reduce (
        .din   (out_data_d),
        .and_o (unused_red_and),
        .or_o  (unused_red_or),
        .xor_o (out_parity_d)
    );
`else
    assign out_parity_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_q       <= '0;
            cnt_q        <= '0;
            msb_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            cnt_q        <= cnt_d;
            msb_q        <= msb_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_parity_q <= out_parity_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_parity = out_parity_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (WORD_W=32, LANE_W=8): order, backpressure,
// back-to-back words, reset mid-word and parity in either build of WORD_SERIALIZER_PARITY_EN.
module tb_word_serializer;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_msb_first;
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] out_data;
    logic              out_last;
    logic              out_parity;
    logic              busy;

    int checks = 0;
    int errors = 0;

    word_serializer #(.WORD_W(WORD_W), .LANE_W(LANE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_parity   (out_parity),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic exp_par(input logic [LANE_W-1:0] d);
`ifdef WORD_SERIALIZER_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL reset_out_parity got=%b exp=0", out_parity); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_release got=%b exp=1", in_ready); end
    endtask

    task automatic test_order(input logic msb);
        logic [7:0] exp_l[4];
        if (msb) exp_l = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        else     exp_l = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hA1B2C3D4; in_msb_first = msb; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL order%0d_accept in_ready got=%b exp=1", msb, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL order%0d_valid beat %0d got=%b exp=1", msb, i, out_valid); end
            checks++; if (out_data !== exp_l[i]) begin errors++; $display("FAIL order%0d_data beat %0d got=%h exp=%h", msb, i, out_data, exp_l[i]); end
            checks++; if (out_last !== (i == 3)) begin errors++; $display("FAIL order%0d_last beat %0d got=%b exp=%b", msb, i, out_last, (i == 3)); end
            checks++; if (out_parity !== exp_par(exp_l[i])) begin errors++; $display("FAIL order%0d_parity beat %0d got=%b exp=%b", msb, i, out_parity, exp_par(exp_l[i])); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order%0d_idle out_valid got=%b exp=0", msb, out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL order%0d_idle busy got=%b exp=0", msb, busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_l[4];
        exp_l = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hA1B2C3D4; in_msb_first = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_data !== 8'hD4) begin errors++; $display("FAIL bp_first got=%h exp=d4", out_data); end
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (out_data !== 8'hC3) begin errors++; $display("FAIL bp_hold_data cycle %0d got=%h exp=c3", c, out_data); end
            checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL bp_hold_last cycle %0d got=%b exp=0", c, out_last); end
            checks++; if (out_parity !== exp_par(8'hC3)) begin errors++; $display("FAIL bp_hold_parity cycle %0d got=%b exp=%b", c, out_parity, exp_par(8'hC3)); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got=%b exp=0", c, in_ready); end
        end
        out_ready = 1'b1;
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_data !== exp_l[i]) begin errors++; $display("FAIL bp_resume beat %0d got=%h exp=%h", i, out_data, exp_l[i]); end
            checks++; if (out_last !== (i == 3)) begin errors++; $display("FAIL bp_resume_last beat %0d got=%b exp=%b", i, out_last, (i == 3)); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_l[8];
        exp_l = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h11223344; in_msb_first = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) in_data = 32'h55667788;
            if (i == 4) in_valid = 1'b0;
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid beat %0d got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== exp_l[i]) begin errors++; $display("FAIL b2b_data beat %0d got=%h exp=%h", i, out_data, exp_l[i]); end
            checks++; if (out_last !== ((i == 3) || (i == 7))) begin errors++; $display("FAIL b2b_last beat %0d got=%b exp=%b", i, out_last, ((i == 3) || (i == 7))); end
            checks++; if (in_ready !== ((i == 3) || (i == 7))) begin errors++; $display("FAIL b2b_in_ready beat %0d got=%b exp=%b", i, in_ready, ((i == 3) || (i == 7))); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_l[4];
        exp_l = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h01020304; in_msb_first = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL rst_mid_pre got=%h exp=02", out_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got=%h exp=00", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_no_replay got=%b exp=0", out_valid); end
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_msb_first = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (out_data !== exp_l[i]) begin errors++; $display("FAIL rst_next_data beat %0d got=%h exp=%h", i, out_data, exp_l[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_parity();
        logic exp_07;
`ifdef WORD_SERIALIZER_PARITY_EN
        exp_07 = 1'b1;
`else
        exp_07 = 1'b0;
`endif
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h00000307; in_msb_first = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_data !== 8'h07) begin errors++; $display("FAIL par_lane07_data got=%h exp=07", out_data); end
        checks++; if (out_parity !== exp_07) begin errors++; $display("FAIL par_lane07 got=%b exp=%b", out_parity, exp_07); end
        @(negedge clk);
        checks++; if (out_data !== 8'h03) begin errors++; $display("FAIL par_lane03_data got=%h exp=03", out_data); end
        checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL par_lane03 got=%b exp=0", out_parity); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_order(1'b0);
        test_order(1'b1);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
